// File: rtl/uart_tx_frames_if.sv
// Serial transmit request/status bundle shared by the core logic (master)
// and the UART transmitter (slave).
interface uart_tx_frames_if #(
    parameter int W = 16
);
    logic         en;
    logic [W-1:0] data;
    logic         tx;
    logic         busy;
    logic         done;

    modport master (
        output en,
        output data,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  en,
        input  data,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx_frames.sv
// Parametrised UART transmitter: serialises NUM_BYTES characters per request,
// one bit per rising edge of the 9600 Hz bit clock, with busy/done handshake.
module uart_tx_frames #(
    parameter int NUM_BYTES  = 2,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic            clk_9k6hz,
    input  logic            rst_n,
    uart_tx_frames_if.slave bus
);
    localparam int W     = NUM_BYTES * DATA_BITS;
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int CHR_W = $clog2(NUM_BYTES + 1);

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [CHR_W-1:0] LAST_CHR  = CHR_W'(NUM_BYTES - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);
    localparam logic [7:0]       LAST_GAP  = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_GAP
    } state_t;

    state_t             r_state,   w_state;
    logic [W-1:0]       r_shift,   w_shift;
    logic [BIT_W-1:0]   r_bitCnt,  w_bitCnt;
    logic [CHR_W-1:0]   r_charIdx, w_charIdx;
    logic [1:0]         r_stopCnt, w_stopCnt;
    logic [7:0]         r_gapCnt,  w_gapCnt;
    logic               r_par,     w_par;
    logic               r_tx,      w_tx;
    logic               r_busy,    w_busy;
    logic               r_done,    w_done;

    always_ff @(posedge clk_9k6hz) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_charIdx <= '0;
            r_stopCnt <= '0;
            r_gapCnt  <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_bitCnt  <= w_bitCnt;
            r_charIdx <= w_charIdx;
            r_stopCnt <= w_stopCnt;
            r_gapCnt  <= w_gapCnt;
            r_par     <= w_par;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    // r_state names the bit currently on tx; each branch chooses the next bit.
    // The whole payload shifts right, so the current character is always in the low bits.
    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_bitCnt  = r_bitCnt;
        w_charIdx = r_charIdx;
        w_stopCnt = r_stopCnt;
        w_gapCnt  = r_gapCnt;
        w_par     = r_par;
        w_tx      = r_tx;
        w_busy    = r_busy;
        w_done    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (bus.en) begin
                    w_shift   = bus.data;
                    w_charIdx = '0;
                    w_busy    = 1'b1;
                    w_tx      = 1'b0;
                    w_state   = S_START;
                end
            end
            S_START: begin
                w_tx     = r_shift[0];
                w_par    = r_shift[0];
                w_shift  = r_shift >> 1;
                w_bitCnt = '0;
                w_state  = S_DATA;
            end
            S_DATA: begin
                if (r_bitCnt == LAST_BIT) begin
                    w_stopCnt = '0;
                    if (PARITY != 0) begin
                        w_tx    = (PARITY == 2) ? ~r_par : r_par;
                        w_state = S_PAR;
                    end else begin
                        w_tx    = 1'b1;
                        w_state = S_STOP;
                    end
                end else begin
                    w_tx     = r_shift[0];
                    w_par    = r_par ^ r_shift[0];
                    w_shift  = r_shift >> 1;
                    w_bitCnt = r_bitCnt + 1'b1;
                end
            end
            S_PAR: begin
                w_tx      = 1'b1;
                w_stopCnt = '0;
                w_state   = S_STOP;
            end
            S_STOP: begin
                w_tx = 1'b1;
                if (r_stopCnt == LAST_STOP) begin
                    if (r_charIdx == LAST_CHR) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        w_gapCnt = '0;
                        w_state  = S_GAP;
                    end else begin
                        w_tx      = 1'b0;
                        w_charIdx = r_charIdx + 1'b1;
                        w_state   = S_START;
                    end
                end else begin
                    w_stopCnt = r_stopCnt + 1'b1;
                end
            end
            S_GAP: begin
                w_tx = 1'b1;
                if (r_gapCnt == LAST_GAP) begin
                    w_tx      = 1'b0;
                    w_charIdx = r_charIdx + 1'b1;
                    w_state   = S_START;
                end else begin
                    w_gapCnt = r_gapCnt + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_uart_tx_frames.sv
// Bench for uart_tx_frames: six parameter sets, per-cycle {tx,busy,done} checks
// against a bit-list model of each request built from the frame rules.
module tb_uart_tx_frames;
    localparam int NCFG = 6;

    logic        clk_9k6hz = 1'b0;
    logic        rst_n;
    int          sel;
    logic        enReq;
    logic [63:0] dataReq;
    logic [2:0]  obs;
    int          testsRun  = 0;
    int          failCount = 0;
    bit          expSeq[$];

    // Configurations: 0 default, 1 even parity, 2 odd parity, 3 gap+2 stop,
    // 4 five-bit x3, 5 mixed seven-bit x3 odd parity with gap
    int cfgNb [NCFG] = '{2, 1, 1, 2, 3, 3};
    int cfgDb [NCFG] = '{8, 8, 8, 8, 5, 7};
    int cfgPar[NCFG] = '{0, 1, 2, 0, 0, 2};
    int cfgSb [NCFG] = '{1, 1, 1, 2, 1, 2};
    int cfgGap[NCFG] = '{0, 0, 0, 3, 0, 2};

    always #5 clk_9k6hz = ~clk_9k6hz;

    uart_tx_frames_if #(.W(16)) ifA ();
    uart_tx_frames_if #(.W(8))  ifB ();
    uart_tx_frames_if #(.W(8))  ifC ();
    uart_tx_frames_if #(.W(16)) ifD ();
    uart_tx_frames_if #(.W(15)) ifE ();
    uart_tx_frames_if #(.W(21)) ifF ();

    assign ifA.en = enReq && (sel == 0);
    assign ifB.en = enReq && (sel == 1);
    assign ifC.en = enReq && (sel == 2);
    assign ifD.en = enReq && (sel == 3);
    assign ifE.en = enReq && (sel == 4);
    assign ifF.en = enReq && (sel == 5);
    assign ifA.data = dataReq[15:0];
    assign ifB.data = dataReq[7:0];
    assign ifC.data = dataReq[7:0];
    assign ifD.data = dataReq[15:0];
    assign ifE.data = dataReq[14:0];
    assign ifF.data = dataReq[20:0];

    uart_tx_frames #(.NUM_BYTES(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(0))
        dutA (.clk_9k6hz(clk_9k6hz), .rst_n(rst_n), .bus(ifA));
    uart_tx_frames #(.NUM_BYTES(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .GAP_CYCLES(0))
        dutB (.clk_9k6hz(clk_9k6hz), .rst_n(rst_n), .bus(ifB));
    uart_tx_frames #(.NUM_BYTES(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .GAP_CYCLES(0))
        dutC (.clk_9k6hz(clk_9k6hz), .rst_n(rst_n), .bus(ifC));
    uart_tx_frames #(.NUM_BYTES(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .GAP_CYCLES(3))
        dutD (.clk_9k6hz(clk_9k6hz), .rst_n(rst_n), .bus(ifD));
    uart_tx_frames #(.NUM_BYTES(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(0))
        dutE (.clk_9k6hz(clk_9k6hz), .rst_n(rst_n), .bus(ifE));
    uart_tx_frames #(.NUM_BYTES(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .GAP_CYCLES(2))
        dutF (.clk_9k6hz(clk_9k6hz), .rst_n(rst_n), .bus(ifF));

    always_comb begin
        obs = 3'b000;
        case (sel)
            0: obs = {ifA.tx, ifA.busy, ifA.done};
            1: obs = {ifB.tx, ifB.busy, ifB.done};
            2: obs = {ifC.tx, ifC.busy, ifC.done};
            3: obs = {ifD.tx, ifD.busy, ifD.done};
            4: obs = {ifE.tx, ifE.busy, ifE.done};
            5: obs = {ifF.tx, ifF.busy, ifF.done};
            default: obs = 3'b000;
        endcase
    end

    // Line contents of one request, bit by bit, from the edge that accepts en
    function automatic void buildSeq(input int idx, input logic [63:0] d);
        bit p;
        bit b;
        expSeq.delete();
        for (int c = 0; c < cfgNb[idx]; c++) begin
            p = 1'b0;
            expSeq.push_back(1'b0);
            for (int k = 0; k < cfgDb[idx]; k++) begin
                b = d[c * cfgDb[idx] + k];
                p = p ^ b;
                expSeq.push_back(b);
            end
            if (cfgPar[idx] == 1) expSeq.push_back(p);
            if (cfgPar[idx] == 2) expSeq.push_back(~p);
            for (int s = 0; s < cfgSb[idx]; s++) expSeq.push_back(1'b1);
            if (c < cfgNb[idx] - 1)
                for (int g = 0; g < cfgGap[idx]; g++) expSeq.push_back(1'b1);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: {tx,busy,done} observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One request; startNow means en is already high and the next edge accepts it.
    // pokeAt>0 pulses en and inverts data at that cycle of the transfer.
    task automatic applyStimulus(input int idx, input logic [63:0] d, input bit startNow,
                                 input bit holdEn, input int pokeAt, input string name);
        int         total;
        logic [2:0] expected;
        buildSeq(idx, d);
        total = expSeq.size();
        if (!startNow) @(negedge clk_9k6hz);
        sel     = idx;
        dataReq = d;
        enReq   = 1'b1;
        for (int j = 0; j <= total; j++) begin
            @(negedge clk_9k6hz);
            expected = (j < total) ? {expSeq[j], 2'b10} : 3'b101;
            checkOutput($sformatf("%s cyc%0d", name, j), obs, expected);
            if (pokeAt > 0 && j == pokeAt) begin
                enReq   = 1'b1;
                dataReq = ~dataReq;
            end else begin
                enReq = holdEn;
            end
        end
        if (!holdEn) begin
            @(negedge clk_9k6hz);
            checkOutput($sformatf("%s idle", name), obs, 3'b100);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        enReq   = 1'b0;
        sel     = 0;
        dataReq = '0;
        repeat (2) @(posedge clk_9k6hz);
        @(negedge clk_9k6hz);
        for (int i = 0; i < NCFG; i++) begin
            sel = i;
            #1;
            checkOutput($sformatf("reset cfg%0d", i), obs, 3'b100);
        end
        rst_n = 1'b1;
        sel   = 0;

        applyStimulus(0, 64'hA53C, 1'b0, 1'b0, 0, "dflt A53C");
        applyStimulus(1, 64'h07, 1'b0, 1'b0, 0, "even 07");
        applyStimulus(2, 64'h07, 1'b0, 1'b0, 0, "odd 07");
        applyStimulus(3, {$urandom, $urandom}, 1'b0, 1'b0, 0, "gap3 stop2");
        applyStimulus(4, 64'h7FFF, 1'b0, 1'b0, 0, "5bit 7FFF");

        // en held through done, second request starts right after the idle cycle
        applyStimulus(0, {$urandom, $urandom}, 1'b0, 1'b1, 0, "b2b first");
        applyStimulus(0, {$urandom, $urandom}, 1'b1, 1'b0, 0, "b2b second");

        // en pulse and data change while busy must not disturb the transfer
        applyStimulus(0, {$urandom, $urandom}, 1'b0, 1'b0, 5, "poke dflt");
        applyStimulus(5, {$urandom, $urandom}, 1'b0, 1'b0, 9, "poke mixed");

        // Reset at edge 6 of a default request aborts it without done
        buildSeq(0, 64'h5AC3);
        @(negedge clk_9k6hz);
        sel     = 0;
        dataReq = 64'h5AC3;
        enReq   = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk_9k6hz);
            enReq = 1'b0;
            checkOutput($sformatf("prereset cyc%0d", j), obs, {expSeq[j], 2'b10});
        end
        rst_n = 1'b0;
        @(negedge clk_9k6hz);
        checkOutput("midreset", obs, 3'b100);
        rst_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk_9k6hz);
            checkOutput($sformatf("postreset quiet%0d", k), obs, 3'b100);
        end
        applyStimulus(0, {$urandom, $urandom}, 1'b0, 1'b0, 0, "after reset");

        for (int r = 0; r < 4; r++) begin
            applyStimulus(r % 5, {$urandom, $urandom}, 1'b0, 1'b0, 0, $sformatf("rand cfg%0d", r % 5));
            applyStimulus(5, {$urandom, $urandom}, 1'b0, 1'b0, 0, $sformatf("rand mixed%0d", r));
        end
        applyStimulus(4, {$urandom, $urandom}, 1'b0, 1'b0, 0, "rand 5bit");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/uart_tx_frames.md
# uart_tx_frames

Parametrised UART transmitter that serialises a multi-byte word on `tx`, one bit per rising edge of the 9600 Hz bit clock. It generalises our two-byte transmitter in several ways: configurable byte count, data width, parity mode, stop-bit count and inter-byte gap. It also adds a proper `busy`/`done` handshake and latches the payload at start. It sits between the core logic that produces result words and the board's serial TX pin.

## Interface
- `NUM_BYTES`, 2: number of characters sent per request (≥1).
- `DATA_BITS`, 8: data bits per character (5..9).
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per character (1 or 2).
- `GAP_CYCLES`, 0: extra idle-high bit times between characters of one request (0..255); not inserted after the last character.

- `clk_9k6hz`  in  1  bit clock; one serial bit per rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  start request; sampled only while idle.
- `data`  in  NUM_BYTES*DATA_BITS  payload; character i = `data[i*DATA_BITS +: DATA_BITS]`, character 0 sent first.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  high from accepted request until the last stop bit ends.
- `done`  out  1  one-cycle pulse when the whole request is finished.

## Operation
- Reset: while `rst_n`=0 at an edge: `tx`=1, `busy`=0, `done`=0, state IDLE, all counters 0. Reset mid-frame aborts the transfer. `tx` is 1 after that edge, and no `done` is issued.
- States: IDLE, START, DATA, PAR, STOP, GAP.
- IDLE: `tx`=1. If `en`=1 at an edge:
  - latch `data` into an internal shift register;
  - set char index 0 and `busy`=1;
  - drive `tx`=0 (start bit) and go to START.
- START (1 bit time) → DATA: each character is sent LSB first, one bit per cycle, for `DATA_BITS` cycles.
- DATA → PAR if `PARITY`≠0, else → STOP.
- PAR: 1 bit time.
  - Even parity: XOR of the character's data bits.
  - Odd parity: the inverse.
- STOP: `tx`=1 for `STOP_BITS` cycles. Then:
  - if more characters remain and `GAP_CYCLES`>0 → GAP;
  - if more remain and `GAP_CYCLES`=0 → START directly (start bit immediately follows the stop bit);
  - if this was the last character → IDLE, with `busy`=0 and `done`=1 at that same edge.
- GAP: `tx`=1 for `GAP_CYCLES` cycles → START of the next character.
- `en` while `busy`=1 is ignored and not queued. Changes on `data` after acceptance have no effect on the transfer in progress.
- `done` is high exactly one cycle and is 0 in all other cycles.

## Timing
- Frame length per character: F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS cycles.
- Request length: T = NUM_BYTES·F + (NUM_BYTES−1)·GAP_CYCLES cycles.
  - Counted from the edge that accepts `en` (start bit appears after that edge) to the edge that raises `done`.
  - Defaults: T = 20.
- Latency from `en` sampled high to first `tx`=0: 0 cycles after the sampling edge. `tx` is registered, so it changes on that edge.
- Back-to-back requests:
  - `en` held high through `done` is accepted at the edge after `done`.
  - This guarantees at least one idle-high bit time between requests.
  - Minimum request period: T+1.
- Counters: bit counter ≥ clog2(DATA_BITS+1) bits; char index ≥ clog2(NUM_BYTES+1) bits; gap counter 8 bits. None may wrap within a request.

## Test plan
- Defaults, `data`=16'hA53C, `en` one cycle → `tx` sequence 0,0,0,1,1,1,1,0,0,1, then 0,1,0,1,0,0,1,0,1,1. `busy`=1 for 20 cycles; `done` pulses at cycle 20; `tx`=1 afterwards.
- NUM_BYTES=1, PARITY=1, then PARITY=2, `data`=8'h07 → parity bit 1 (even) and 0 (odd). Frame is 11 cycles; `done` at cycle 11.
- GAP_CYCLES=3, STOP_BITS=2, defaults otherwise → 3 high cycles between character 0's two stop bits and character 1's start bit. `done` at cycle 2·11+3 = 25.
- `en` held high continuously → second request's start bit appears exactly 1 idle cycle after `done`. `en` pulses during `busy` and `data` changes after acceptance do not alter the `tx` sequence.
- Reset: `rst_n`=0 for one edge at cycle 6 of a default request → `tx`=1, `busy`=0, and no `done` ever pulses. A new `en` afterwards produces a clean full 20-cycle frame.
- DATA_BITS=5, NUM_BYTES=3, `data`=15'h7FFF → three frames of 0,1,1,1,1,1,1 back to back. `done` at cycle 21.
